shift_sequencer: RTL

//  Multi-cycle controller for the ALU shift path. Accepts a shift request
//  (SLL/SRL/SRA) via a start/done handshake and decomposes the shift amount

---
 rtl/shift_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: decomposes the shift amount into LOG2W power-of-two
// stages applied one per cycle through a single stage shifter.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int LOG2W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int SW = (LOG2W > 1) ? $clog2(LOG2W) : 1;
  localparam logic [WIDTH-1:0] MAX_AMT = WIDTH'(WIDTH - 1);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LOG2W-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [LOG2W-1:0] step_amt;
  logic [WIDTH-1:0] stage_out;

  // Shared stage shifter: one power-of-two step selected by the current stage.
  always_comb begin
    step_amt = LOG2W'(1) << stage_q;
    case (op_q)
      OP_SLL:  stage_out = acc_q << step_amt;
      OP_SRL:  stage_out = acc_q >> step_amt;
      OP_SRA:  stage_out = WIDTH'($signed(acc_q) >>> step_amt);
      default: stage_out = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    stage_d  = stage_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          acc_d = in_a;
          b_d   = in_b[LOG2W-1:0];
          op_d  = op;
          if (op == OP_ILL) begin
            result_d = in_a;
            err_d    = 1'b1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (in_b > MAX_AMT) begin
            // Amount shifts every bit out: the outcome is just the fill value.
            result_d = (op == OP_SRA) ? {WIDTH{in_a[WIDTH-1]}} : '0;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            stage_d = SW'(LOG2W - 1);
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (b_q[stage_q]) begin
          acc_d = stage_out;
        end
        if (stage_q == '0) begin
          result_d = acc_d;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          stage_d = stage_q - SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      stage_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      stage_q  <= stage_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
